// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared FP32 field constants, operand classes and classifier
package fp32_pkg;
    localparam int FP32_SIGN_W   = 1;
    localparam int FP32_EXP_W    = 8;
    localparam int FP32_FRAC_W   = 23;
    localparam int FP32_EXP_BIAS = 127;
    localparam int FP32_EXP_MAX  = 255;
    localparam logic [31:0] FP32_QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp32_class_t;

    // Subnormals classify as ZERO: this family flushes them on input.
    function automatic fp32_class_t fp32_classify(input logic [31:0] x);
        if (x[30:23] == 8'd0) begin
            return ZERO;
        end else if (x[30:23] == 8'hFF) begin
            return (x[22:0] == 23'd0) ? INF : NAN;
        end else begin
            return NORM;
        end
    endfunction
endpackage

// File: rtl/fp32_round_pack.sv
// rtl/fp32_round_pack.sv - RNE rounding, range clamp and special-case override into a packed FP32
module fp32_round_pack
    import fp32_pkg::*;
(
    input  logic        i_sign,
    input  logic [9:0]  i_exp,
    input  logic [22:0] i_mant,
    input  logic        i_guard,
    input  logic        i_sticky,
    input  logic [1:0]  i_cls_a,
    input  logic [1:0]  i_cls_b,
    output logic [31:0] o_result
);
    logic              w_round_up;
    logic [23:0]       w_mant_rnd;
    logic signed [9:0] w_exp_rnd;
    logic              w_nan;
    logic              w_inf;
    logic              w_zero;

    assign w_round_up = i_guard & (i_sticky | i_mant[0]);
    // A carry out of the mantissa leaves the fraction bits at zero, so only the exponent moves.
    assign w_mant_rnd = {1'b0, i_mant} + {23'd0, w_round_up};
    assign w_exp_rnd  = $signed(i_exp) + $signed({9'd0, w_mant_rnd[23]});

    assign w_nan  = (i_cls_a == NAN) || (i_cls_b == NAN)
                 || ((i_cls_a == INF) && (i_cls_b == ZERO))
                 || ((i_cls_a == ZERO) && (i_cls_b == INF));
    assign w_inf  = (i_cls_a == INF) || (i_cls_b == INF);
    assign w_zero = (i_cls_a == ZERO) || (i_cls_b == ZERO);

    always_comb begin
        o_result = {i_sign, w_exp_rnd[7:0], w_mant_rnd[22:0]};
        if (w_nan) begin
            o_result = FP32_QNAN;
        end else if (w_inf) begin
            o_result = {i_sign, 8'hFF, 23'd0};
        end else if (w_zero) begin
            o_result = {i_sign, 31'd0};
        end else if (w_exp_rnd >= 10'sd255) begin
            o_result = {i_sign, 8'hFF, 23'd0};
        end else if (w_exp_rnd <= 10'sd0) begin
            o_result = {i_sign, 31'd0};
        end
    end
endmodule

// File: rtl/fp_mul_pl.sv
// rtl/fp_mul_pl.sv - 3-cycle pipelined FP32 multiplier (unpack / normalize / round), flush-to-zero
module fp_mul_pl
    import fp32_pkg::*;
#(
    parameter int FTZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D,
    output logic [31:0] C,
    output logic        V
);
    generate
        if (FTZ != 1) begin : g_ftz_check
            $error("fp_mul_pl only implements FTZ=1");
        end
    endgenerate

    logic [47:0] w_mant_a;
    logic [47:0] w_mant_b;
    logic [9:0]  w_exp_sum;
    logic [1:0]  w_cls_a;
    logic [1:0]  w_cls_b;

    logic        r1_vld, r1_sign;
    logic [9:0]  r1_exp;
    logic [47:0] r1_prod;
    logic [1:0]  r1_cls_a, r1_cls_b;

    logic [9:0]  w_exp_n;
    logic [22:0] w_mant_n;
    logic        w_guard_n, w_sticky_n;

    logic        r2_vld, r2_sign, r2_guard, r2_sticky;
    logic [9:0]  r2_exp;
    logic [22:0] r2_mant;
    logic [1:0]  r2_cls_a, r2_cls_b;

    logic [31:0] w_result;
    logic        r3_vld;
    logic [31:0] r3_result;

    assign w_mant_a  = {24'd0, |A[30:23], A[22:0]};
    assign w_mant_b  = {24'd0, |B[30:23], B[22:0]};
    assign w_exp_sum = {2'b00, A[30:23]} + {2'b00, B[30:23]} - 10'(FP32_EXP_BIAS);
    assign w_cls_a   = fp32_classify(A);
    assign w_cls_b   = fp32_classify(B);

    always_comb begin
        if (r1_prod[47]) begin
            w_exp_n    = r1_exp + 10'd1;
            w_mant_n   = r1_prod[46:24];
            w_guard_n  = r1_prod[23];
            w_sticky_n = |r1_prod[22:0];
        end else begin
            w_exp_n    = r1_exp;
            w_mant_n   = r1_prod[45:23];
            w_guard_n  = r1_prod[22];
            w_sticky_n = |r1_prod[21:0];
        end
    end

    fp32_round_pack u_round_pack (
        .i_sign   (r2_sign),
        .i_exp    (r2_exp),
        .i_mant   (r2_mant),
        .i_guard  (r2_guard),
        .i_sticky (r2_sticky),
        .i_cls_a  (r2_cls_a),
        .i_cls_b  (r2_cls_b),
        .o_result (w_result)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r1_vld <= 1'b0;
            r2_vld <= 1'b0;
            r3_vld <= 1'b0;
            V      <= 1'b0;
            C      <= 32'h0;
        end else begin
            r1_vld <= D;
            r2_vld <= r1_vld;
            r3_vld <= r2_vld;
            V      <= r3_vld;
            if (r3_vld) begin
                C <= r3_result;
            end
        end
    end

    // Payload registers need no reset: the valid chain alone decides what reaches C.
    always_ff @(posedge clk) begin
        r1_sign   <= A[31] ^ B[31];
        r1_exp    <= w_exp_sum;
        r1_prod   <= w_mant_a * w_mant_b;
        r1_cls_a  <= w_cls_a;
        r1_cls_b  <= w_cls_b;
        r2_sign   <= r1_sign;
        r2_exp    <= w_exp_n;
        r2_mant   <= w_mant_n;
        r2_guard  <= w_guard_n;
        r2_sticky <= w_sticky_n;
        r2_cls_a  <= r1_cls_a;
        r2_cls_b  <= r1_cls_b;
        r3_result <= w_result;
    end
endmodule

// File: tb/tb_fp_mul_pl.sv
// tb/tb_fp_mul_pl.sv - scoreboard bench for fp_mul_pl with directed hand-computed vectors
module tb_fp_mul_pl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, B, C;
    logic        D, V;

    always #5 clk = ~clk;

    fp_mul_pl #(.FTZ(1)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .D   (D),
        .C   (C),
        .V   (V)
    );

    typedef struct packed {
        logic [31:0] res;
        int          issue;
        logic [95:0] name;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int          edge_cnt = 0;
    logic        rst_at_edge = 1'b1;
    logic [31:0] last_c = 32'h0;

    always @(posedge clk) begin
        edge_cnt    <= edge_cnt + 1;
        rst_at_edge <= rst;
    end

    always @(negedge clk) begin
        if (edge_cnt > 0) begin
            if (!rst_at_edge) begin
                checks++;
                if (C !== 32'h0) begin
                    failures++;
                    $display("FAIL rst_c: got %h want %h", C, 32'h0);
                end
                checks++;
                if (V !== 1'b0) begin
                    failures++;
                    $display("FAIL rst_v: got %b want 0", V);
                end
                last_c = 32'h0;
            end else if (V === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_v: got V=1 C=%h want no result", C);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (C !== e.res) begin
                        failures++;
                        $display("FAIL %0s: got %h want %h", e.name, C, e.res);
                    end
                    checks++;
                    if (edge_cnt - e.issue != 3) begin
                        failures++;
                        $display("FAIL %0s_latency: got %0d want 3", e.name, edge_cnt - e.issue);
                    end
                end
                last_c = C;
            end else begin
                checks++;
                if (V !== 1'b0 || C !== last_c) begin
                    failures++;
                    $display("FAIL hold: got V=%b C=%h want V=0 C=%h", V, C, last_c);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input logic [95:0] name);
        exp_t e;
        A = a;
        B = b;
        D = 1'b1;
        e.res   = expv;
        e.issue = edge_cnt + 1;
        e.name  = name;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        D = 1'b0;
        for (int i = 0; i < n; i++) begin
            A = $urandom;
            B = $urandom;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        D = 1'b0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", q.size());
            q.delete();
        end
        idle(2);
    endtask

    initial begin
        rst = 1'b0;
        D   = 1'b0;
        A   = 32'h0;
        B   = 32'h0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        issue(32'h40000000, 32'h3F800000, 32'h40000000, "two_x_one");
        issue(32'h447A0000, 32'h3F800000, 32'h447A0000, "thousand");
        issue(32'h3FC00000, 32'h3E000000, 32'h3E400000, "p1875");
        issue(32'hC0000000, 32'h40400000, 32'hC0C00000, "neg_six");
        issue(32'h3F800001, 32'h3F800001, 32'h3F800002, "sticky");
        issue(32'h3FC00001, 32'h3FC00000, 32'h40100001, "round_up");
        issue(32'h3F800001, 32'h3FC00000, 32'h3FC00002, "tie_odd");
        issue(32'h3F800003, 32'h3FC00000, 32'h3FC00004, "tie_even");
        issue(32'h7F800000, 32'h00000000, 32'h7FC00000, "inf_x_zero");
        issue(32'h7F000000, 32'h40000000, 32'h7F800000, "overflow");
        issue(32'h00800000, 32'h00800000, 32'h00000000, "underflow");
        issue(32'h00000001, 32'h40000000, 32'h00000000, "subnorm_in");
        issue(32'hFFC00000, 32'h3F800000, 32'h7FC00000, "nan_in");
        issue(32'hFF800000, 32'h40000000, 32'hFF800000, "neg_inf");
        issue(32'h80000000, 32'h40000000, 32'h80000000, "neg_zero");
        drain();

        issue(32'h40000000, 32'h40000000, 32'h40800000, "bubble_a");
        idle(2);
        issue(32'h40400000, 32'h40400000, 32'h41100000, "bubble_b");
        drain();

        A = 32'h40000000;
        B = 32'h40000000;
        D = 1'b1;
        @(posedge clk);
        #1;
        A = 32'h40400000;
        @(posedge clk);
        #1;
        D   = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(8);

        issue(32'h42100000, 32'h3E800000, 32'h41100000, "rt_exact");
        issue(32'h3EAAAAAB, 32'h40400000, 32'h3F800000, "rt_third");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
